// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_serial_adder
//  Description : Sequential N-nibble adder around an external 4-bit lookahead
//                slice. Operands are processed one nibble per clock, least
//                significant nibble first. The slice carry is registered and
//                fed back as the carry-in of the next nibble. Operands and
//                results move over valid/ready handshakes.
//                Optional feature macro: NSA_SUB_EN (adds in_sub, A - B).
//  Revision    : 1.0  initial release
// ============================================================================
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   op_a,
    input  logic [4*NIBBLES-1:0]   op_b,
    input  logic                   op_cin,
`ifdef NSA_SUB_EN
    input  logic                   in_sub,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout,
    output logic                   ovf,
    output logic [3:0]             add_a,
    output logic [3:0]             add_b,
    output logic                   add_cin,
    input  logic [3:0]             add_s,
    input  logic                   add_cout
);

    localparam int c_w     = 4 * NIBBLES;
    localparam int c_idx_w = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [c_idx_w-1:0] c_last = c_idx_w'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_w-1:0]       r_a_sh;
    logic [c_w-1:0]       r_b_sh;
    logic [c_w-1:0]       r_sum;
    logic                 r_carry;
    logic [c_idx_w-1:0]   r_idx;
    logic                 r_cout;
    logic                 r_ovf;

    logic [c_w-1:0]       w_b_eff;
    logic                 w_cin_eff;
    logic [c_w+3:0]       w_sum_cat;
    logic [c_w-1:0]       w_sum_next;
    logic                 w_ovf;
    logic                 w_run;

    // Effective B operand and carry-in; subtraction is A + ~B + 1.
`ifdef NSA_SUB_EN
    assign w_b_eff   = in_sub ? ~op_b : op_b;
    assign w_cin_eff = in_sub ? 1'b1  : op_cin;
`else
    assign w_b_eff   = op_b;
    assign w_cin_eff = op_cin;
`endif

    // New slice sum enters at the top; after NIBBLES shifts nibble 0 sits at the bottom.
    assign w_sum_cat  = {add_s, r_sum};
    assign w_sum_next = w_sum_cat[c_w+3:4];

    // On the final nibble the low bits of the operand shifters hold the MSB nibbles.
    assign w_ovf = (r_a_sh[3] == r_b_sh[3]) && (add_s[3] != r_a_sh[3]);

    assign w_run = (r_state == S_RUN);

    // Slice drive is gated to zero whenever no nibble is being processed.
    always_comb begin
        add_a   = 4'd0;
        add_b   = 4'd0;
        add_cin = 1'b0;
        if (w_run) begin
            add_a   = r_a_sh[3:0];
            add_b   = r_b_sh[3:0];
            add_cin = r_carry;
        end
    end

    assign in_ready  = (r_state == S_IDLE) && !rst;
    assign out_valid = (r_state == S_DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

    // Control FSM and nibble datapath: accept, shift one nibble per clock, hold result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a_sh  <= op_a;
                        r_b_sh  <= w_b_eff;
                        r_carry <= w_cin_eff;
                        r_idx   <= '0;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
                        r_ovf   <= 1'b0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_sum   <= w_sum_next;
                    r_a_sh  <= r_a_sh >> 4;
                    r_b_sh  <= r_b_sh >> 4;
                    r_carry <= add_cout;
                    r_idx   <= r_idx + 1'b1;
                    if (r_idx == c_last) begin
                        r_cout  <= add_cout;
                        r_ovf   <= w_ovf;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nibble_serial_adder
//  Description : Self-checking bench for nibble_serial_adder (NIBBLES=4) with
//                an ideal 4-bit adder on the slice ports and a behavioural
//                reference model. Subtract cases run when NSA_SUB_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_nibble_serial_adder;

    localparam int NIB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        op_cin = 1'b0;
    logic        tb_sub = 1'b0;
    logic [15:0] op_a = 16'd0;
    logic [15:0] op_b = 16'd0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic [3:0]  add_a;
    logic [3:0]  add_b;
    logic [3:0]  add_s;
    logic        add_cin;
    logic        add_cout;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Ideal 4-bit slice.
    assign {add_cout, add_s} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

    nibble_serial_adder #(.NIBBLES(NIB)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op_a     (op_a),
        .op_b     (op_b),
        .op_cin   (op_cin),
`ifdef NSA_SUB_EN
        .in_sub   (tb_sub),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_s    (add_s),
        .add_cout (add_cout)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [15:0] m_a, m_b;
    logic        m_c;
    bit          m_busy, m_done;
    int          m_step;

    wire [15:0] beff = tb_sub ? ~op_b : op_b;
    wire        ceff = tb_sub ? 1'b1 : op_cin;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_step <= 0;
        end else if (!m_busy && !m_done) begin
            if (in_valid) begin
                m_a    <= op_a;
                m_b    <= beff;
                m_c    <= ceff;
                m_busy <= 1'b1;
                m_step <= 0;
            end
        end else if (m_busy) begin
            m_step <= m_step + 1;
            if (m_step == NIB - 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
            end
        end else if (out_ready) begin
            m_done <= 1'b0;
        end
    end

    function automatic logic [16:0] full_sum();
        return {1'b0, m_a} + {1'b0, m_b} + 17'(m_c);
    endfunction

    function automatic logic carry_into(int step);
        logic [31:0] mask, t;
        mask = (32'd1 << (4 * step)) - 32'd1;
        t = (32'(m_a) & mask) + (32'(m_b) & mask) + 32'(m_c);
        return t[4 * step];
    endfunction

    // Single per-cycle compare process.
    always @(negedge clk) begin
        logic [16:0] r;
        if (rst) begin
            chk("rst_in_ready", 32'(in_ready), 32'd0);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_sum", 32'(sum), 32'd0);
            chk("rst_cout", 32'(cout), 32'd0);
            chk("rst_ovf", 32'(ovf), 32'd0);
            chk("rst_add_a", 32'(add_a), 32'd0);
            chk("rst_add_cin", 32'(add_cin), 32'd0);
        end else begin
            chk("in_ready", 32'(in_ready), 32'(!m_busy && !m_done));
            chk("out_valid", 32'(out_valid), 32'(m_done));
            if (m_busy) begin
                chk("add_a", 32'(add_a), 32'((m_a >> (4 * m_step)) & 16'hF));
                chk("add_b", 32'(add_b), 32'((m_b >> (4 * m_step)) & 16'hF));
                chk("add_cin", 32'(add_cin), 32'(carry_into(m_step)));
            end else begin
                chk("add_idle", 32'({add_a, add_b, add_cin}), 32'd0);
            end
            if (m_done) begin
                r = full_sum();
                chk("sum", 32'(sum), 32'(r[15:0]));
                chk("cout", 32'(cout), 32'(r[16]));
                chk("ovf", 32'(ovf), 32'((m_a[15] == m_b[15]) && (r[15] != m_a[15])));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                          input logic s, input int hold, input bit lit,
                          input logic [15:0] es, input logic ec, input logic eo,
                          input bit seqchk, input logic [15:0] aseq, input logic [3:0] cseq);
        int t;
        logic [15:0] got_a;
        logic [3:0]  got_c;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            return;
        end
        in_valid = 1'b1;
        op_a = a;
        op_b = b;
        op_cin = c;
        tb_sub = s;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        op_a = 16'($urandom);
        op_b = 16'($urandom);
        for (int i = 0; i < NIB; i++) begin
            got_a = {got_a[11:0], add_a};
            got_c = {got_c[2:0], add_cin};
            @(negedge clk);
        end
        chk("latency_out_valid", 32'(out_valid), 32'd1);
        if (lit) begin
            chk("lit_sum", 32'(sum), 32'(es));
            chk("lit_cout", 32'(cout), 32'(ec));
            chk("lit_ovf", 32'(ovf), 32'(eo));
        end
        if (seqchk) begin
            chk("lit_add_a_seq", 32'(got_a), 32'(aseq));
            chk("lit_add_cin_seq", 32'(got_c), 32'(cseq));
        end
        t = 0;
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            op_a = 16'($urandom);
            op_b = 16'($urandom);
            tb_sub = 1'b0;
            @(negedge clk);
        end
        if (hold > 0 && lit) begin
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_sum", 32'(sum), 32'(es));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("idle_after_done", 32'(in_ready), 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        #2 rst = 1'b0;

        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0, 1, 16'h5555, 1'b0, 1'b0, 1, 16'h4321, 4'b0000);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1, 16'h0000, 1'b1, 1'b0, 1, 16'hFFFF, 4'b0111);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 1, 16'h8000, 1'b0, 1'b1, 0, 16'h0, 4'h0);
        run_op(16'h8000, 16'h8000, 1'b0, 1'b0, 0, 1, 16'h0000, 1'b1, 1'b1, 0, 16'h0, 4'h0);
        run_op(16'h0F0F, 16'h1111, 1'b0, 1'b0, 6, 1, 16'h2020, 1'b0, 1'b0, 0, 16'h0, 4'h0);

        // Reset two cycles into RUN; the partial result must never surface.
        @(negedge clk);
        in_valid = 1'b1;
        op_a = 16'h1111;
        op_b = 16'h2222;
        op_cin = 1'b0;
        tb_sub = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        chk("midrst_add_a", 32'(add_a), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("midrst_no_valid", 32'(out_valid), 32'd0);
        end
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0, 1, 16'h0002, 1'b0, 1'b0, 0, 16'h0, 4'h0);

`ifdef NSA_SUB_EN
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0, 1, 16'hFFFE, 1'b0, 1'b0, 0, 16'h0, 4'h0);
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0, 1, 16'h7FFF, 1'b1, 1'b1, 0, 16'h0, 4'h0);
`endif

        for (int n = 0; n < 40; n++) begin
            logic s;
`ifdef NSA_SUB_EN
            s = 1'($urandom);
`else
            s = 1'b0;
`endif
            run_op(16'($urandom), 16'($urandom), 1'($urandom), s,
                   int'($urandom_range(0, 3)), 0, 16'h0, 1'b0, 1'b0, 0, 16'h0, 4'h0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Sequential N-nibble adder that drives an external 4-bit carry-lookahead adder slice one nibble per clock, least-significant nibble first, and feeds the registered slice carry back as the next nibble's carry-in. It sits directly around the 4-bit adder: it feeds that adder's operand and carry inputs and consumes its sum and carry outputs. Wide additions therefore reuse a single 4-bit lookahead slice. Operands arrive over a valid/ready handshake, and results leave over one.

## Interface
- NIBBLES, default 4: operand width in nibbles (W = 4*NIBBLES bits); legal range ≥1.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair offered.
- in_ready  output  1  block accepts operands; high only in IDLE.
- op_a  input  W  operand A.
- op_b  input  W  operand B.
- op_cin  input  1  carry-in to nibble 0.
- in_sub  input  1  present only with NSA_SUB_EN: subtract B from A.
- out_valid  output  1  result held; high only in DONE.
- out_ready  input  1  consumer takes result.
- sum  output  W  result.
- cout  output  1  carry out of MSB nibble.
- ovf  output  1  two's-complement signed overflow.
- add_a  output  4  nibble to slice operand A.
- add_b  output  4  nibble to slice operand B.
- add_cin  output  1  carry to slice.
- add_s  input  4  slice sum (combinational from add_a/add_b/add_cin).
- add_cout  input  1  slice carry out.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE: in_ready=1. On in_valid&in_ready, capture op_a and effective B into shift registers, set carry register = effective cin, set nibble index = 0, and go to RUN.
- RUN: add_a = a_sh[3:0], add_b = b_sh[3:0], add_cin = carry register.
  - Each clock: shift add_s into the top nibble of the sum shift register, shift a_sh/b_sh right by 4, set carry <= add_cout, index++.
  - When index == NIBBLES-1 on that edge, latch cout <= add_cout and go to DONE.
- DONE: out_valid=1; sum, cout and ovf are stable. On out_ready, go to IDLE.
- ovf = (A[W-1] == Beff[W-1]) && (sum[W-1] != A[W-1]), computed from the captured MSBs and registered on entry to DONE.
- add_a/add_b/add_cin are 0 outside RUN.
- in_valid is ignored outside IDLE. out_ready is ignored outside DONE.
- Arithmetic is modulo 2^W; no internal width growth beyond cout.

## Timing
- Reset values: in_ready=0 during reset and 1 after release (IDLE). out_valid=0, sum=0, cout=0, ovf=0, add_a=0, add_b=0, add_cin=0.
- Accept on edge k; the RUN nibbles are consumed on edges k+1 … k+NIBBLES; out_valid is high from edge k+NIBBLES.
- Latency from accept to out_valid is NIBBLES cycles.
- The DONE→IDLE transition takes one edge, so the minimum initiation interval is NIBBLES+2 cycles.
- NIBBLES=1: a single RUN cycle, then DONE.
- out_ready held low: DONE persists indefinitely with all outputs frozen; in_ready stays 0.
- rst asserted mid-RUN or mid-DONE: the state returns to IDLE immediately (asynchronously) and all registers clear. The partial result is discarded and never presented.
- The slice path add_a → add_s → sum register must close in one cycle.

## Configuration
- NSA_SUB_EN defined:
  - The in_sub port exists.
  - At accept, effective B = in_sub ? ~op_b : op_b and effective cin = in_sub ? 1 : op_cin.
  - cout is then the not-borrow flag.
  - ovf uses effective B.
- NSA_SUB_EN undefined: no in_sub port; effective B = op_b and effective cin = op_cin.

## Test plan
All cases use NIBBLES=4 with an ideal 4-bit adder model on the slice ports.
- Add: 0x1234 + 0x4321, cin=0, accepted at edge k → out_valid at k+4, sum=0x5555, cout=0, ovf=0; add_a sequence 4,3,2,1.
- Carry ripple: 0xFFFF + 0x0001, cin=0 → sum=0x0000, cout=1, ovf=0; add_cin sequence 0,1,1,1.
- Overflow: 0x7FFF + 0x0001 → sum=0x8000, cout=0, ovf=1. Also 0x8000 + 0x8000 → sum=0x0000, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 6 cycles after out_valid → sum/cout/ovf unchanged, in_ready=0, a new in_valid is ignored. Raise out_ready → IDLE next edge and in_ready=1.
- Reset mid-op: assert rst two cycles into RUN → all outputs 0 at once, out_valid never pulses. After release, 0x0001 + 0x0001 → 0x0002.
- NSA_SUB_EN: in_sub=1, 0x0005 − 0x0007 → sum=0xFFFE, cout=0, ovf=0. Also 0x8000 − 0x0001 → sum=0x7FFF, cout=1, ovf=1.
